// File: rtl/data_record_gen.sv
// -----------------------------------------------------------------------------
// data_record_gen
//   Transmit-side framer for the ETROC2 readout record stream. Each accepted
//   event is sent as a header, its data words and a CRC8-protected trailer;
//   idle words fill the gaps between frames. One 40-bit record per clock.
//
//   Ports:
//     clk            40 MHz clock
//     reset          synchronous, active-low reset
//     evtValid/evtReady        event descriptor handshake
//     evtBCID, evtL1Status, evtSEU, evtHasHits   event descriptor fields
//     hitValid, hitData, hitLast   hit stream from the L1 buffer
//     hitRead        hit consumed this cycle (combinational)
//     dataRecord     registered 40-bit record stream
//     frameCount     trailers emitted (wraps)
//     underrunCount  frames truncated by a hit underrun (wraps)
//     injErr         trailer error injection, present only when the macro
//                    DATA_RECORD_GEN_ERRINJ_EN is defined
//
//   CHIPID must not be 17'h0F170 or 17'h0F172 (header/idle marker aliases).
//   CRC8: polynomial 0x2F, zero init, non-reflected, MSB first, computed as
//   the plain remainder so that the residue over header..trailer is zero.
// -----------------------------------------------------------------------------
module data_record_gen #(
    parameter logic [16:0] CHIPID = 17'h1B0E5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        evtValid,
    output logic        evtReady,
    input  logic [11:0] evtBCID,
    input  logic [1:0]  evtL1Status,
    input  logic        evtSEU,
    input  logic        evtHasHits,
    input  logic        hitValid,
    input  logic [38:0] hitData,
    input  logic        hitLast,
    output logic        hitRead,
    output logic [39:0] dataRecord,
    output logic [19:0] frameCount,
    output logic [15:0] underrunCount
`ifdef DATA_RECORD_GEN_ERRINJ_EN
    ,
    input  logic [1:0]  injErr
`endif
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_DATA   = 2'd1;
    localparam logic [1:0]  ST_TRAIL  = 2'd2;
    localparam logic [1:0]  ST_DRAIN  = 2'd3;

    localparam logic [39:0] IDLE_WORD = {16'h3C5C, 2'b10, 22'h2AAAAA};
    localparam logic [7:0]  CRC_POLY  = 8'h2F;

    // Remainder-form CRC8: each message bit is shifted in at the bottom.
    function automatic logic [7:0] crc8_word(input logic [7:0] crc_in,
                                             input logic [39:0] word);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 39; i >= 0; i--) begin
            fb = c[7];
            c  = {c[6:0], word[i]};
            if (fb) begin
                c = c ^ CRC_POLY;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    // Trailer with its CRC over the zero-padded word; inj bit 1 bumps the
    // emitted count (CRC covers the bumped value), bit 0 flips CRC[0].
    function automatic logic [39:0] make_trailer(input logic [7:0] crc_run,
                                                 input logic [1:0] status,
                                                 input logic       seu,
                                                 input logic       trunc,
                                                 input logic [7:0] cnt,
                                                 input logic [1:0] inj);
        logic [39:0] t;
        t = {1'b0, CHIPID, status, seu, trunc, 2'b00,
             cnt + {7'd0, inj[1]}, 8'h00};
        t[7:0] = crc8_word(crc_run, t) ^ {7'd0, inj[0]};
        return t;
    endfunction

    logic [1:0]  state_r, state_n;
    logic [9:0]  evt_num_r, evt_num_n;
    logic [7:0]  crc_r, crc_n;
    logic [7:0]  hit_cnt_r, hit_cnt_n;
    logic        pend_r, pend_n;
    logic        gap_r, gap_n;
    logic [1:0]  status_r, status_n;
    logic        seu_r, seu_n;
    logic [39:0] rec_n;
    logic [19:0] frames_n;
    logic [15:0] under_n;
    logic [39:0] header_s;
    logic [39:0] data_word_s;
    logic [7:0]  hit_cnt_inc_s;
    logic [1:0]  inj_s;

`ifdef DATA_RECORD_GEN_ERRINJ_EN
    assign inj_s = injErr;
`else
    assign inj_s = 2'b00;
`endif

    assign header_s      = {16'h3C5C, 2'b00, evt_num_r, evtBCID};
    assign data_word_s   = {1'b1, hitData};
    assign hit_cnt_inc_s = hit_cnt_r + 8'd1;

    // Handshake outputs. gap_r holds off acceptance for the single idle
    // cycle that must follow a trailer emitted straight into IDLE.
    always_comb begin
        if (reset && (state_r == ST_IDLE) && !gap_r) begin
            evtReady = 1'b1;
        end else begin
            evtReady = 1'b0;
        end
        if (reset && hitValid && ((state_r == ST_DATA) || (state_r == ST_DRAIN))) begin
            hitRead = 1'b1;
        end else begin
            hitRead = 1'b0;
        end
    end

    // Next-state and next-record computation for the framer.
    always_comb begin
        state_n   = state_r;
        evt_num_n = evt_num_r;
        crc_n     = crc_r;
        hit_cnt_n = hit_cnt_r;
        pend_n    = pend_r;
        gap_n     = 1'b0;
        status_n  = status_r;
        seu_n     = seu_r;
        rec_n     = IDLE_WORD;
        frames_n  = frameCount;
        under_n   = underrunCount;
        case (state_r)
            ST_IDLE: begin
                if (evtValid && !gap_r) begin
                    rec_n     = header_s;
                    evt_num_n = evt_num_r + 10'd1;
                    status_n  = evtL1Status;
                    seu_n     = evtSEU;
                    hit_cnt_n = 8'd0;
                    crc_n     = crc8_word(8'h00, header_s);
                    // Overflow/full events never emit hits; queued hits
                    // are drained after the trailer instead.
                    if (evtHasHits && !evtL1Status[1]) begin
                        state_n = ST_DATA;
                        pend_n  = 1'b0;
                    end else begin
                        state_n = ST_TRAIL;
                        pend_n  = evtHasHits;
                    end
                end else begin
                    rec_n = IDLE_WORD;
                end
            end
            ST_DATA: begin
                if (hitValid) begin
                    rec_n     = data_word_s;
                    crc_n     = crc8_word(crc_r, data_word_s);
                    hit_cnt_n = hit_cnt_inc_s;
                    if (hitLast) begin
                        state_n = ST_TRAIL;
                        pend_n  = 1'b0;
                    end else if (hit_cnt_inc_s == 8'd255) begin
                        state_n = ST_TRAIL;
                        pend_n  = 1'b1;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    // Underrun: close the frame now, flag it truncated.
                    rec_n    = make_trailer(crc_r, status_r, seu_r, 1'b1, hit_cnt_r, inj_s);
                    crc_n    = 8'h00;
                    pend_n   = 1'b1;
                    frames_n = frameCount + 20'd1;
                    under_n  = underrunCount + 16'd1;
                    state_n  = ST_DRAIN;
                end
            end
            ST_TRAIL: begin
                rec_n    = make_trailer(crc_r, status_r, seu_r, 1'b0, hit_cnt_r, inj_s);
                crc_n    = 8'h00;
                frames_n = frameCount + 20'd1;
                if (pend_r) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_IDLE;
                    gap_n   = 1'b1;
                end
            end
            ST_DRAIN: begin
                rec_n = IDLE_WORD;
                if (hitValid && hitLast) begin
                    state_n = ST_IDLE;
                    pend_n  = 1'b0;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            evt_num_r     <= 10'd0;
            crc_r         <= 8'h00;
            hit_cnt_r     <= 8'd0;
            pend_r        <= 1'b0;
            gap_r         <= 1'b0;
            status_r      <= 2'b00;
            seu_r         <= 1'b0;
            dataRecord    <= IDLE_WORD;
            frameCount    <= 20'd0;
            underrunCount <= 16'd0;
        end else begin
            state_r       <= state_n;
            evt_num_r     <= evt_num_n;
            crc_r         <= crc_n;
            hit_cnt_r     <= hit_cnt_n;
            pend_r        <= pend_n;
            gap_r         <= gap_n;
            status_r      <= status_n;
            seu_r         <= seu_n;
            dataRecord    <= rec_n;
            frameCount    <= frames_n;
            underrunCount <= under_n;
        end
    end

endmodule
